// File: rtl/stepper_step_generator_if.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_step_generator_if
//  Description : Step-request handshake between the motion controller
//                (master) and the step generator (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface stepper_step_generator_if;
    logic EnablexS;   // permits acceptance of new steps
    logic StepReqxS;  // step request (valid)
    logic StepDirxS;  // requested direction, 1 = positive
    logic StepAckxS;  // ready; handshake when StepReqxS & StepAckxS

    modport master (
        output EnablexS,
        output StepReqxS,
        output StepDirxS,
        input  StepAckxS
    );

    modport slave (
        input  EnablexS,
        input  StepReqxS,
        input  StepDirxS,
        output StepAckxS
    );
endinterface
`default_nettype wire

// File: rtl/stepper_step_generator.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_step_generator
//  Description : Turns single-step requests into STEP/DIR driver signals with
//                guaranteed pulse width, inter-pulse gap and direction setup,
//                and keeps a signed wrapping position counter.
//  Revision    : 1.0  initial release
// ============================================================================
module stepper_step_generator #(
    parameter int g_PulseWidth    = 256,
    parameter int g_PulseGap      = 256,
    parameter int g_DirSetup      = 64,
    parameter int g_CounterWidth  = 16,
    parameter int g_PositionWidth = 32
) (
    input  wire logic                        ClkxC,
    input  wire logic                        ResetxRN,
    stepper_step_generator_if.slave          s_step,
    output logic                             StepOutxS,
    output logic                             DirOutxS,
    output logic                             BusyxS,
    input  wire logic                        PosLoadxS,
    input  wire logic [g_PositionWidth-1:0]  PosLoadValxD,
    output logic      [g_PositionWidth-1:0]  PositionxD
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_DIR_SETUP  = 2'd1,
        S_PULSE_HIGH = 2'd2,
        S_PULSE_GAP  = 2'd3
    } state_t;

    // Counter reload values: each state lasts (value + 1) cycles.
    localparam logic [g_CounterWidth-1:0] c_PW_LOAD = g_CounterWidth'(g_PulseWidth - 1);
    localparam logic [g_CounterWidth-1:0] c_PG_LOAD = g_CounterWidth'(g_PulseGap - 1);
    localparam logic [g_CounterWidth-1:0] c_DS_LOAD = g_CounterWidth'(g_DirSetup - 1);

    state_t                     r_state;
    logic [g_CounterWidth-1:0]  r_cnt;
    logic                       r_step;
    logic                       r_dir;
    logic                       r_busy;
    logic                       r_rdy;     // registered "in IDLE and out of reset"
    logic [g_PositionWidth-1:0] r_pos;

    logic w_accept;
    logic w_cnt_zero;
    logic w_step_edge;

    assign w_accept   = r_rdy & s_step.EnablexS & s_step.StepReqxS;
    assign w_cnt_zero = (r_cnt == '0);

    // STEP rises either straight from IDLE (no direction change) or at the
    // end of the direction setup window; the position moves with that edge.
    assign w_step_edge = ((r_state == S_IDLE) && w_accept && (s_step.StepDirxS == r_dir)) ||
                         ((r_state == S_DIR_SETUP) && w_cnt_zero);

    assign s_step.StepAckxS = r_rdy & s_step.EnablexS;
    assign StepOutxS        = r_step;
    assign DirOutxS         = r_dir;
    assign BusyxS           = r_busy;
    assign PositionxD       = r_pos;

    // Step sequencing FSM with registered STEP/DIR/BUSY/ready outputs.
    always_ff @(posedge ClkxC or negedge ResetxRN) begin
        if (!ResetxRN) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rdy  <= 1'b0;
                        r_busy <= 1'b1;
                        if (s_step.StepDirxS == r_dir) begin
                            r_state <= S_PULSE_HIGH;
                            r_step  <= 1'b1;
                            r_cnt   <= c_PW_LOAD;
                        end else begin
                            r_state <= S_DIR_SETUP;
                            r_dir   <= s_step.StepDirxS;
                            r_cnt   <= c_DS_LOAD;
                        end
                    end else begin
                        r_rdy <= 1'b1;
                    end
                end
                S_DIR_SETUP: begin
                    if (w_cnt_zero) begin
                        r_state <= S_PULSE_HIGH;
                        r_step  <= 1'b1;
                        r_cnt   <= c_PW_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_PULSE_HIGH: begin
                    if (w_cnt_zero) begin
                        r_state <= S_PULSE_GAP;
                        r_step  <= 1'b0;
                        r_cnt   <= c_PG_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_PULSE_GAP: begin
                    if (w_cnt_zero) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_rdy   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_step  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

    // Position counter: a load overrides a coincident step update.
    always_ff @(posedge ClkxC or negedge ResetxRN) begin
        if (!ResetxRN) begin
            r_pos <= '0;
        end else if (PosLoadxS) begin
            r_pos <= PosLoadValxD;
        end else if (w_step_edge) begin
            r_pos <= r_dir ? (r_pos + 1'b1) : (r_pos - 1'b1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stepper_step_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stepper_step_generator
//  Description : Directed self-checking bench for stepper_step_generator.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stepper_step_generator;

    logic        clk;
    logic        rst_n;
    logic        pos_load;
    logic [31:0] pos_load_val;
    logic        step_out;
    logic        dir_out;
    logic        busy;
    logic [31:0] position;

    int n_checks = 0;
    int n_errors = 0;
    int n;
    int rises;

    stepper_step_generator_if bus ();

    stepper_step_generator dut (
        .ClkxC        (clk),
        .ResetxRN     (rst_n),
        .s_step       (bus.slave),
        .StepOutxS    (step_out),
        .DirOutxS     (dir_out),
        .BusyxS       (busy),
        .PosLoadxS    (pos_load),
        .PosLoadValxD (pos_load_val),
        .PositionxD   (position)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycles spent with step_out at lvl, starting from the current cycle.
    task automatic count_level(input logic lvl, output int cnt);
        cnt = 0;
        while (step_out === lvl && cnt < 5000) begin
            cnt++;
            tick();
        end
    endtask

    // Cycles until the ready/ack output comes up.
    task automatic count_until_ack(output int cnt);
        cnt = 0;
        while (bus.StepAckxS !== 1'b1 && cnt < 5000) begin
            cnt++;
            tick();
        end
    endtask

    // Cycles until step_out goes high.
    task automatic count_until_step(output int cnt);
        cnt = 0;
        while (step_out !== 1'b1 && cnt < 5000) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.EnablexS  = 1'b1;
        bus.StepReqxS = 1'b0;
        bus.StepDirxS = 1'b0;
        pos_load      = 1'b0;
        pos_load_val  = 32'h0;
        repeat (3) tick();

        // Reset state
        check("rst_step", {31'b0, step_out}, 32'd0);
        check("rst_dir",  {31'b0, dir_out}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ack",  {31'b0, bus.StepAckxS}, 32'd0);
        check("rst_pos",  position, 32'd0);

        rst_n = 1'b1;
        tick();
        check("idle_ack", {31'b0, bus.StepAckxS}, 32'd1);

        // Same-direction single step (dir=0): high 256, gap 256, ack at 513
        bus.StepReqxS = 1'b1;
        bus.StepDirxS = 1'b0;
        tick();
        bus.StepReqxS = 1'b0;
        check("t1_step_c1", {31'b0, step_out}, 32'd1);
        check("t1_pos",     position, 32'hFFFF_FFFF);
        check("t1_busy",    {31'b0, busy}, 32'd1);
        check("t1_ack_low", {31'b0, bus.StepAckxS}, 32'd0);
        count_level(1'b1, n);
        check("t1_high_len", n, 32'd256);
        count_until_ack(n);
        check("t1_gap_len", n, 32'd256);
        check("t1_step_idle", {31'b0, step_out}, 32'd0);
        check("t1_busy_idle", {31'b0, busy}, 32'd0);

        // Direction change plus three held back-to-back steps
        bus.StepReqxS = 1'b1;
        bus.StepDirxS = 1'b1;
        tick();
        check("t2_dir_c1",  {31'b0, dir_out}, 32'd1);
        check("t2_step_c1", {31'b0, step_out}, 32'd0);
        check("t2_busy",    {31'b0, busy}, 32'd1);
        count_until_step(n);
        check("t2_setup_len", n, 32'd64);
        check("t2_pos1", position, 32'd0);
        count_level(1'b1, n);
        check("t2_high1", n, 32'd256);
        count_until_step(n);
        check("t2_spacing2", n, 32'd257);
        check("t2_pos2", position, 32'd1);
        count_level(1'b1, n);
        check("t2_high2", n, 32'd256);
        count_until_step(n);
        check("t2_spacing3", n, 32'd257);
        check("t2_pos3", position, 32'd2);
        check("t2_dir_hold", {31'b0, dir_out}, 32'd1);
        bus.StepReqxS = 1'b0;
        count_level(1'b1, n);
        check("t2_high3", n, 32'd256);
        count_until_ack(n);
        check("t2_gap3", n, 32'd256);

        // Enable dropped at cycle 100 of a pulse
        bus.StepReqxS = 1'b1;
        tick();
        bus.StepReqxS = 1'b0;
        check("t3_pos", position, 32'd3);
        repeat (99) tick();
        bus.EnablexS = 1'b0;
        count_level(1'b1, n);
        check("t3_high_rest", n, 32'd157);
        bus.StepReqxS = 1'b1;
        rises = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (step_out === 1'b1) rises++;
        end
        check("t3_no_pulse", rises, 32'd0);
        check("t3_ack_dis",  {31'b0, bus.StepAckxS}, 32'd0);
        check("t3_busy_dis", {31'b0, busy}, 32'd0);
        bus.EnablexS = 1'b1;
        tick();
        bus.StepReqxS = 1'b0;
        check("t3_reen_step", {31'b0, step_out}, 32'd1);
        check("t3_reen_pos",  position, 32'd4);
        count_level(1'b1, n);
        check("t3_reen_high", n, 32'd256);
        count_until_ack(n);

        // Load coinciding with a step edge wins; next step wraps
        bus.StepReqxS = 1'b1;
        pos_load      = 1'b1;
        pos_load_val  = 32'h7FFF_FFFF;
        tick();
        bus.StepReqxS = 1'b0;
        pos_load      = 1'b0;
        check("t4_load_step", {31'b0, step_out}, 32'd1);
        check("t4_load_pos",  position, 32'h7FFF_FFFF);
        count_level(1'b1, n);
        check("t4_load_high", n, 32'd256);
        count_until_ack(n);
        bus.StepReqxS = 1'b1;
        tick();
        bus.StepReqxS = 1'b0;
        check("t4_wrap_pos", position, 32'h8000_0000);

        // Asynchronous reset during PULSE_HIGH
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_step_async", {31'b0, step_out}, 32'd0);
        check("t5_pos",  position, 32'd0);
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_dir",  {31'b0, dir_out}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_ack_after", {31'b0, bus.StepAckxS}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
